// File: rtl/game_pkg.sv
// game_pkg: shared game state encoding, key codes and arithmetic helpers
package game_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PLAYING = 2'b01,
        DEAD    = 2'b10
    } game_state_t;

    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    // geometry never goes below zero, so a left edge past column 0 pins to 0
    function automatic logic [10:0] sub_clamp(input logic [10:0] a, input logic [10:0] b);
        return (a > b) ? a - b : 11'd0;
    endfunction

    // two-digit BCD increment; caller handles saturation at 99
    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        return (s[3:0] == 4'd9) ? {s[7:4] + 4'd1, 4'd0} : {s[7:4], s[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// frame_tick_sync: brings the frame clock into the system domain as a one-cycle tick
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic async_in,
    output logic tick
);

    logic [2:0] sync;

    // two metastability flops, one history flop, registered rising-edge pulse
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync <= '0;
            tick <= 1'b0;
        end else begin
            sync <= {sync[1:0], async_in};
            tick <= sync[1] & ~sync[2];
        end
    end

endmodule

// File: rtl/game_referee.sv
// game_referee: game FSM, collision/pass detection and BCD score keeping
module game_referee
    import game_pkg::*;
#(
    parameter logic [10:0] PIPE_HALF_W = 11'd16,
    parameter logic [10:0] GAP_HALF    = 11'd48,
    parameter logic [10:0] FLOOR_Y     = 11'd479,
    parameter logic [10:0] SCREEN_W    = 11'd640,
    parameter logic [7:0]  FLAP_KEY    = KEY_W,
    parameter logic [7:0]  START_KEY   = KEY_SPACE
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic [9:0] BirdX,
    input  logic [9:0] BirdY,
    input  logic [9:0] BirdS,
    input  logic [9:0] PipeX,
    input  logic [9:0] PipeGapY,
    output logic [1:0] game_state,
    output logic [7:0] score_bcd,
    output logic       hit,
    output logic       score_inc
);

    game_state_t state, state_n;
    logic [7:0]  last_key, score_n;
    logic        tick, armed, armed_n, hit_n, inc_n;
    logic        press_start, press_flap;
    logic [10:0] bx, by, bs, px, gy;
    logic [10:0] bird_l, bird_r, bird_t, bird_b, pipe_l, pipe_r, gap_t, gap_b;
    logic        offscreen, pipe_hit, bound_hit, passed;

    frame_tick_sync u_sync (
        .Clk     (Clk),
        .Reset   (Reset),
        .async_in(frame_clk),
        .tick    (tick)
    );

    assign press_start = (keycode == START_KEY) && (last_key != START_KEY);
    assign press_flap  = (keycode == FLAP_KEY) && (last_key != FLAP_KEY);

    assign bx = {1'b0, BirdX};
    assign by = {1'b0, BirdY};
    assign bs = {1'b0, BirdS};
    assign px = {1'b0, PipeX};
    assign gy = {1'b0, PipeGapY};

    assign bird_l = sub_clamp(bx, bs);
    assign bird_r = bx + bs;
    assign bird_t = sub_clamp(by, bs);
    assign bird_b = by + bs;
    assign pipe_l = sub_clamp(px, PIPE_HALF_W);
    assign pipe_r = px + PIPE_HALF_W;
    assign gap_t  = sub_clamp(gy, GAP_HALF);
    assign gap_b  = gy + GAP_HALF;

    // a pipe wrapped past column 0 shows up as a huge X and must not collide
    assign offscreen = px > SCREEN_W + PIPE_HALF_W;
    assign pipe_hit  = !offscreen && bird_r >= pipe_l && bird_l <= pipe_r && (bird_t < gap_t || bird_b > gap_b);
    assign bound_hit = bird_b >= FLOOR_Y || by <= bs;
    assign passed    = !offscreen && pipe_r < bird_l;

    assign game_state = state;

    // next state, score and pulses; collision takes priority over scoring
    always_comb begin
        state_n = state;
        score_n = score_bcd;
        armed_n = (tick && offscreen) ? 1'b1 : armed;
        hit_n   = 1'b0;
        inc_n   = 1'b0;
        case (state)
            IDLE: begin
                if (press_start || press_flap) begin
                    state_n = PLAYING;
                    score_n = 8'h00;
                    armed_n = 1'b1;
                end
            end
            PLAYING: begin
                if (tick && (pipe_hit || bound_hit)) begin
                    state_n = DEAD;
                    hit_n   = 1'b1;
                end else if (tick && passed && armed) begin
                    armed_n = 1'b0;
                    inc_n   = score_bcd != 8'h99;
                    score_n = inc_n ? bcd_inc(score_bcd) : score_bcd;
                end
            end
            DEAD:    state_n = press_start ? IDLE : DEAD;
            default: state_n = IDLE;
        endcase
    end

    // state, score, pass arming, key history and registered pulses
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            score_bcd <= 8'h00;
            armed     <= 1'b1;
            hit       <= 1'b0;
            score_inc <= 1'b0;
            last_key  <= 8'h00;
        end else begin
            state     <= state_n;
            score_bcd <= score_n;
            armed     <= armed_n;
            hit       <= hit_n;
            score_inc <= inc_n;
            last_key  <= keycode;
        end
    end

endmodule

// File: tb/tb_game_referee.sv
// tb_game_referee: scoreboard bench for the game referee
module tb_game_referee;

    typedef struct packed {
        logic       hit;
        logic       inc;
        logic [1:0] st;
        logic [7:0] sc;
    } ev_t;

    logic       clk = 0, rst = 1, frame_clk = 0;
    logic [7:0] keycode = 0;
    logic [9:0] BirdX = 300, BirdY = 240, BirdS = 4, PipeX = 700, PipeGapY = 240;
    logic [1:0] game_state;
    logic [7:0] score_bcd;
    logic       hit, score_inc;

    ev_t        exp_q[$];
    int         checks = 0, errors = 0;
    logic       mon_en = 0;
    logic [1:0] prev_st;
    logic [7:0] prev_sc;

    game_referee dut (
        .Clk       (clk),
        .Reset     (rst),
        .frame_clk (frame_clk),
        .keycode   (keycode),
        .BirdX     (BirdX),
        .BirdY     (BirdY),
        .BirdS     (BirdS),
        .PipeX     (PipeX),
        .PipeGapY  (PipeGapY),
        .game_state(game_state),
        .score_bcd (score_bcd),
        .hit       (hit),
        .score_inc (score_inc)
    );

    always #5 clk = ~clk;

    // monitor: any pulse or change of state/score is an event matched against the queue
    always @(negedge clk) begin
        if (mon_en) begin
            if (hit || score_inc || game_state != prev_st || score_bcd != prev_sc) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got hit=%0b inc=%0b state=%0d score=%h, expected no event",
                             hit, score_inc, game_state, score_bcd);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    if ({hit, score_inc, game_state, score_bcd} !== e) begin
                        errors++;
                        $display("FAIL event: got hit=%0b inc=%0b state=%0d score=%h, expected hit=%0b inc=%0b state=%0d score=%h",
                                 hit, score_inc, game_state, score_bcd, e.hit, e.inc, e.st, e.sc);
                    end
                end
            end
            prev_st <= game_state;
            prev_sc <= score_bcd;
        end
    end

    task automatic expect_ev(input logic h, input logic i, input logic [1:0] st, input logic [7:0] sc);
        exp_q.push_back({h, i, st, sc});
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic press(input logic [7:0] k);
        @(negedge clk);
        keycode = k;
        repeat (2) @(negedge clk);
        keycode = 8'h00;
        repeat (2) @(negedge clk);
    endtask

    task automatic frame(input logic [9:0] px, input logic [9:0] y, input logic [9:0] s);
        @(negedge clk);
        PipeX = px;
        BirdY = y;
        BirdS = s;
        frame_clk = 1;
        repeat (6) @(negedge clk);
        frame_clk = 0;
        repeat (3) @(negedge clk);
    endtask

    function automatic logic [7:0] to_bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_state", {6'd0, game_state}, 8'h00);
        chk("reset_score", score_bcd, 8'h00);
        chk("reset_hit", {7'd0, hit}, 8'h00);
        chk("reset_inc", {7'd0, score_inc}, 8'h00);
        rst = 0;
        prev_st = game_state;
        prev_sc = score_bcd;
        mon_en = 1;
        repeat (2) @(negedge clk);

        // flap starts the game; holding the key causes nothing more
        expect_ev(0, 0, 2'b01, 8'h00);
        keycode = 8'h1A;
        repeat (100) @(negedge clk);
        keycode = 8'h00;
        repeat (2) @(negedge clk);

        // pipe sweeps past a bird sitting in the gap; first pass at PipeX=279
        for (int x = 330; x >= 270; x--) begin
            if (x == 279) expect_ev(0, 1, 2'b01, 8'h01);
            frame(10'(x), 10'd240, 10'd4);
        end

        // further passes, each re-armed by an off-screen pipe, up to 99
        for (int n = 2; n <= 99; n++) begin
            frame(10'd700, 10'd240, 10'd4);
            expect_ev(0, 1, 2'b01, to_bcd(n));
            frame(10'd270, 10'd240, 10'd4);
        end
        frame(10'd700, 10'd240, 10'd4);
        frame(10'd270, 10'd240, 10'd4);
        chk("saturate_99", score_bcd, 8'h99);

        // bird above the gap inside the pipe column dies; score then frozen
        expect_ev(1, 0, 2'b10, 8'h99);
        frame(10'd300, 10'd150, 10'd4);
        frame(10'd700, 10'd240, 10'd4);
        frame(10'd270, 10'd240, 10'd4);
        press(8'h1A);
        chk("dead_flap_ignored", {6'd0, game_state}, 8'h02);
        expect_ev(0, 0, 2'b00, 8'h99);
        press(8'h2C);
        expect_ev(0, 0, 2'b01, 8'h00);
        press(8'h2C);

        // floor contact
        expect_ev(1, 0, 2'b10, 8'h00);
        frame(10'd700, 10'd475, 10'd4);
        expect_ev(0, 0, 2'b00, 8'h00);
        press(8'h2C);
        expect_ev(0, 0, 2'b01, 8'h00);
        press(8'h1A);

        // wrapped pipe never collides; then collision and pass on one tick
        frame(10'd1010, 10'd240, 10'd4);
        chk("wrapped_alive", {6'd0, game_state}, 8'h01);
        expect_ev(1, 0, 2'b10, 8'h00);
        frame(10'd270, 10'd475, 10'd4);
        expect_ev(0, 0, 2'b00, 8'h00);
        press(8'h2C);
        expect_ev(0, 0, 2'b01, 8'h00);
        press(8'h2C);

        // top of bird touching row 0
        expect_ev(1, 0, 2'b10, 8'h00);
        frame(10'd700, 10'd4, 10'd4);
        expect_ev(0, 0, 2'b00, 8'h00);
        press(8'h2C);
        expect_ev(0, 0, 2'b01, 8'h00);
        press(8'h2C);

        // build score to 37, then reset with a frame edge in flight
        for (int n = 1; n <= 37; n++) begin
            frame(10'd700, 10'd240, 10'd4);
            expect_ev(0, 1, 2'b01, to_bcd(n));
            frame(10'd270, 10'd240, 10'd4);
        end
        chk("score_37", score_bcd, 8'h37);
        @(negedge clk);
        expect_ev(0, 0, 2'b00, 8'h00);
        rst = 1;
        frame_clk = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        repeat (6) @(negedge clk);
        frame_clk = 0;
        repeat (3) @(negedge clk);
        chk("midreset_state", {6'd0, game_state}, 8'h00);
        chk("midreset_score", score_bcd, 8'h00);

        repeat (10) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events: got %0d unconsumed, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
